// File: rtl/step_sequencer.sv
// step_sequencer: generates the 2-bit current_step sequence for the CPU's
// value_capture stages. One step per clock, stalls on memory steps until
// mem_ready, halts only at instruction boundaries, and faults permanently
// when a memory step waits too long.
module step_sequencer #(
  parameter int           STEPS          = 4,        // 2..4
  parameter logic [3:0]   WAIT_STEP_MASK = 4'b0010,  // bit n: step n waits for mem_ready
  parameter int           TIMEOUT_CYCLES = 16        // 1..255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
  input  logic        mem_ready,
  output logic        mem_request,
  output logic [1:0]  current_step,
  output logic [3:0]  step_done,
  output logic        instruction_done,
  output logic        halted,
  output logic        timeout,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  // Mask bits for steps that never occur are dropped so they cannot stall.
  localparam logic [3:0] VALID_MASK   = 4'((1 << STEPS) - 1);
  localparam logic [3:0] EFF_MASK     = WAIT_STEP_MASK & VALID_MASK;
  localparam logic [1:0] LAST_STEP    = 2'(STEPS - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_step;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_count;

  logic w_running;
  logic w_wait_step;
  logic w_stall;
  logic w_advance;
  logic w_last_step;

  assign w_running   = (r_state == ST_RUN);
  assign w_wait_step = EFF_MASK[r_step];
  assign w_stall     = w_running && w_wait_step && !mem_ready;
  // Pulses are suppressed in a reset cycle so no completion is reported for
  // an instruction that is being abandoned.
  assign w_advance   = w_running && !w_stall && !reset;
  assign w_last_step = (r_step == LAST_STEP);

  assign mem_request      = w_running && w_wait_step;
  assign instruction_done = w_advance && w_last_step;
  assign current_step     = r_step;
  assign halted           = (r_state != ST_RUN);
  assign timeout          = (r_state == ST_FAULT);
  assign stall_count      = r_stall_count;

  // One-hot completion pulse for the step that advances this cycle.
  always_comb begin
    // NOTE: defaulting every output first keeps this block free of latches.
    step_done = 4'b0000;
    if (w_advance) begin
      step_done[r_step] = 1'b1;
    end
  end

  // Sequencer FSM: run/halt control, step advance, wait counting and fault.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state       <= ST_HALTED;
      r_step        <= 2'd0;
      r_wait_cnt    <= 8'd0;
      r_stall_count <= 16'd0;
    end else begin
      case (r_state)
        ST_HALTED: begin
          r_step     <= 2'd0;
          r_wait_cnt <= 8'd0;
          if (run) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_stall) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_stall_count != 16'hFFFF) begin
              r_stall_count <= r_stall_count + 16'd1;
            end
            // This unready cycle is the TIMEOUT_CYCLES-th in a row.
            if (r_wait_cnt == TIMEOUT_LAST) begin
              r_state <= ST_FAULT;
            end
          end else begin
            r_wait_cnt <= 8'd0;
            if (w_last_step) begin
              r_step <= 2'd0;
              // run/halt_req only matter at the instruction boundary.
              if (halt_req || !run) begin
                r_state <= ST_HALTED;
              end
            end else begin
              r_step <= r_step + 2'd1;
            end
          end
        end

        ST_FAULT: begin
          // Terminal until reset; everything frozen.
          r_state <= ST_FAULT;
        end

        default: begin
          r_state <= ST_HALTED;
          r_step  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed stimulus against two sequencer instances
// (4 steps / step-1 wait, and 3 steps / out-of-range wait bit), a
// spec-level model checked every cycle, plus literal expectations.
module tb_step_sequencer;

  logic clock = 1'b0;
  logic reset, run, halt_req, mem_ready;

  logic        req   [2];
  logic [1:0]  step  [2];
  logic [3:0]  sdone [2];
  logic        idone [2];
  logic        hlt   [2];
  logic        tmo   [2];
  logic [15:0] stall [2];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  step_sequencer #(.STEPS(4), .WAIT_STEP_MASK(4'b0010), .TIMEOUT_CYCLES(16)) dut_a (
    .clock(clock), .reset(reset), .run(run), .halt_req(halt_req), .mem_ready(mem_ready),
    .mem_request(req[0]), .current_step(step[0]), .step_done(sdone[0]),
    .instruction_done(idone[0]), .halted(hlt[0]), .timeout(tmo[0]), .stall_count(stall[0]));

  step_sequencer #(.STEPS(3), .WAIT_STEP_MASK(4'b1000), .TIMEOUT_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset), .run(run), .halt_req(halt_req), .mem_ready(mem_ready),
    .mem_request(req[1]), .current_step(step[1]), .step_done(sdone[1]),
    .instruction_done(idone[1]), .halted(hlt[1]), .timeout(tmo[1]), .stall_count(stall[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = halted, 1 = running, 2 = faulted
  int nsteps [2] = '{4, 3};
  int mask   [2] = '{2, 8};
  int m_mode [2], m_step [2], m_wait [2], m_stall [2];
  bit m_valid = 0;
  bit b_ever_req = 0;

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      bit is_wait, adv, exp_req;
      is_wait = (m_step[d] < nsteps[d]) && ((mask[d] >> m_step[d]) & 1);
      exp_req = (m_mode[d] == 1) && is_wait;
      adv     = (m_mode[d] == 1) && !reset && !(is_wait && !mem_ready);
      if (m_valid) begin
        check($sformatf("dut%0d current_step", d), 32'(step[d]), 32'(m_step[d]));
        check($sformatf("dut%0d mem_request", d), 32'(req[d]), 32'(exp_req));
        check($sformatf("dut%0d step_done", d), 32'(sdone[d]), adv ? (32'd1 << m_step[d]) : 32'd0);
        check($sformatf("dut%0d instruction_done", d), 32'(idone[d]),
              32'(adv && (m_step[d] == nsteps[d] - 1)));
        check($sformatf("dut%0d halted", d), 32'(hlt[d]), 32'(m_mode[d] != 1));
        check($sformatf("dut%0d timeout", d), 32'(tmo[d]), 32'(m_mode[d] == 2));
        check($sformatf("dut%0d stall_count", d), 32'(stall[d]), 32'(m_stall[d]));
        if (d == 1 && req[1] === 1'b1) b_ever_req = 1;
      end
      // Predict the state after the coming rising edge.
      if (reset) begin
        m_mode[d] = 0; m_step[d] = 0; m_wait[d] = 0; m_stall[d] = 0;
      end else if (m_mode[d] == 0) begin
        if (run) m_mode[d] = 1;
      end else if (m_mode[d] == 1) begin
        if (!adv) begin
          m_wait[d]++;
          if (m_stall[d] < 65535) m_stall[d]++;
          if (m_wait[d] == 16) m_mode[d] = 2;
        end else begin
          m_wait[d] = 0;
          if (m_step[d] == nsteps[d] - 1) begin
            m_step[d] = 0;
            if (halt_req || !run) m_mode[d] = 0;
          end else begin
            m_step[d]++;
          end
        end
      end
    end
    if (reset) m_valid = 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1; run = 0; halt_req = 0; mem_ready = 1;
    tick(2);
    check("reset halted", 32'(hlt[0]), 1);
    check("reset step", 32'(step[0]), 0);
    check("reset stall_count", 32'(stall[0]), 0);
    check("reset timeout", 32'(tmo[0]), 0);
    reset = 0;
    tick();
    check("idle halted", 32'(hlt[0]), 1);

    // Free-running sequence with zero-wait memory.
    run = 1;
    tick();
    check("run step0", 32'(step[0]), 0);
    check("run not halted", 32'(hlt[0]), 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("seq A i=%0d", i), 32'(step[0]), 32'(i % 4));
      check($sformatf("seq B i=%0d", i), 32'(step[1]), 32'(i % 3));
    end
    check("seq stall_count", 32'(stall[0]), 0);

    // Step 1 stalled three cycles, then memory completes.
    tick();
    mem_ready = 0;
    tick();
    check("wait entry step", 32'(step[0]), 1);
    tick(3);
    check("wait held step", 32'(step[0]), 1);
    check("wait mem_request", 32'(req[0]), 1);
    mem_ready = 1;
    #1;
    check("wait release pulse", 32'(sdone[0]), 32'h2);
    tick();
    check("wait advanced", 32'(step[0]), 2);
    check("wait stall_count", 32'(stall[0]), 3);

    // halt_req mid-instruction is ignored; run=0 at step 3 halts.
    tick(3);
    halt_req = 1;
    tick();
    halt_req = 0;
    check("halt mid ignored", 32'(hlt[0]), 0);
    tick();
    check("at last step", 32'(step[0]), 3);
    run = 0;
    #1;
    check("boundary instruction_done", 32'(idone[0]), 1);
    tick();
    check("halted after boundary", 32'(hlt[0]), 1);
    check("halted step", 32'(step[0]), 0);
    tick(3);

    // run and halt_req together: one instruction then halt.
    run = 1; halt_req = 1;
    tick();
    check("one-shot running", 32'(hlt[0]), 0);
    tick(4);
    check("one-shot halted", 32'(hlt[0]), 1);
    halt_req = 0;
    tick(4);

    // Reset during a wait on step 1.
    tick();
    mem_ready = 0;
    tick(3);
    check("pre-reset waiting", 32'(step[0]), 1);
    reset = 1; mem_ready = 1;
    #1;
    check("reset cycle step_done", 32'(sdone[0]), 0);
    check("reset cycle instruction_done", 32'(idone[0]), 0);
    tick();
    check("post-reset step", 32'(step[0]), 0);
    check("post-reset halted", 32'(hlt[0]), 1);
    check("post-reset stall_count", 32'(stall[0]), 0);
    reset = 0;
    tick();
    check("restart step", 32'(step[0]), 0);
    check("restart running", 32'(hlt[0]), 0);

    // Timeout: 16 consecutive unready cycles on step 1.
    mem_ready = 0;
    tick();
    check("timeout entry step", 32'(step[0]), 1);
    tick(15);
    check("15 waits no fault", 32'(tmo[0]), 0);
    tick();
    check("fault timeout", 32'(tmo[0]), 1);
    check("fault halted", 32'(hlt[0]), 1);
    check("fault step frozen", 32'(step[0]), 1);
    check("fault stall_count", 32'(stall[0]), 16);
    mem_ready = 1; run = 0;
    tick(2);
    run = 1;
    tick(3);
    check("fault sticky", 32'(tmo[0]), 1);
    check("fault mem_request", 32'(req[0]), 0);
    check("fault step still", 32'(step[0]), 1);

    reset = 1;
    tick();
    reset = 0;
    tick(6);
    check("B never requested", 32'(b_ever_req), 0);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
